inv_scheduler: RTL and testbench

- Shares one modular-inverse core (operands A, p; outputs X, result_ready) between NREQ requesters, such as point-add and point-double sequencers.
- Arbitrates requests round-robin and launches the core with the winner's operand.
- Waits for result_ready, or aborts on a timeout.
- Returns the inverse to the winner with a one-cycle done pulse. It sits between the ECC point-arithmetic controllers and the inverse core.

---
 rtl/inv_scheduler.sv | 108 ++++++++++
 tb/tb_inv_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_scheduler.sv
// inv_scheduler: round-robin arbiter sharing one modular-inverse core between NREQ requesters,
// with launch sequencing, timeout abort and a one-cycle done pulse back to the winner.
module inv_scheduler #(
  parameter int N       = 231,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 2048,
  parameter int CW      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*N-1:0] a_in_i,
  input  logic [N-1:0]      p_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [N-1:0]      result_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              inv_reset_o,
  output logic [N-1:0]      inv_a_o,
  output logic [N-1:0]      inv_p_o,
  input  logic [N-1:0]      inv_x_i,
  input  logic              inv_ready_i
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q, pick;
  logic [NREQ-1:0]   gnt_q, done_q;
  logic [N-1:0]      result_q, inv_a_q, pick_a;
  logic              err_q, inv_reset_q, found;
  logic [CW-1:0]     cnt_q;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v >= NREQ ? v - NREQ : v);
  endfunction

  // Scan offsets from the far end so the requester closest to ptr wins.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_i[wrap(int'(ptr_q) + k)]) begin
        pick  = wrap(int'(ptr_q) + k);
        found = 1'b1;
      end
    pick_a = a_in_i[int'(pick)*N +: N];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      inv_reset_q <= 1'b1;
      inv_a_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          gnt_q   <= NREQ'(1) << pick;
          inv_a_q <= pick_a;
          ptr_q   <= wrap(int'(pick) + 1);
          if (pick_a == '0) begin
            result_q <= '0;
            err_q    <= 1'b1;
            done_q   <= NREQ'(1) << pick;
            state_q  <= DONE;
          end else state_q <= LAUNCH;
        end
        LAUNCH: begin
          cnt_q       <= '0;
          inv_reset_q <= 1'b0;
          state_q     <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (inv_ready_i || cnt_q == CW'(TIMEOUT - 1)) begin
            result_q    <= inv_ready_i ? inv_x_i : '0;
            err_q       <= !inv_ready_i;
            done_q      <= gnt_q;
            inv_reset_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          gnt_q   <= '0;
          done_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign err_o       = err_q;
  assign busy_o      = state_q != IDLE;
  assign inv_reset_o = inv_reset_q;
  assign inv_a_o     = inv_a_q;
  assign inv_p_o     = p_i;
endmodule

// File: tb/tb_inv_scheduler.sv
// tb_inv_scheduler: inverse-core stub plus transaction-level reference model of the scheduler,
// directed scenarios followed by randomized multi-requester traffic.
module tb_inv_scheduler;
  localparam int N = 8, NREQ = 3, TO = 16, CW = 5;

  logic clk = 0, rst_n = 0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*N-1:0] a_in = '0;
  logic [N-1:0] p = 8'd7;
  logic [NREQ-1:0] gnt, done;
  logic [N-1:0] result, inv_a, inv_p, inv_x;
  logic err, busy, inv_reset, inv_ready;
  int core_cyc = 0, lat = 1000;
  logic force_rdy = 0;
  int checks = 0, failures = 0, ncyc = 0;
  logic [NREQ-1:0] prev_gnt = '0;

  int m_owner = -1, m_age = 0, m_ptr = 0;
  logic m_end = 0, m_err = 0;
  logic [N-1:0] m_res = '0, m_a = '0;

  always #5 clk = ~clk;

  inv_scheduler #(.N(N), .NREQ(NREQ), .TIMEOUT(TO), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .a_in_i(a_in), .p_i(p),
    .gnt_o(gnt), .done_o(done), .result_o(result), .err_o(err), .busy_o(busy),
    .inv_reset_o(inv_reset), .inv_a_o(inv_a), .inv_p_o(inv_p),
    .inv_x_i(inv_x), .inv_ready_i(inv_ready)
  );

  function automatic logic [N-1:0] inv_mod(input logic [N-1:0] a, input logic [N-1:0] m);
    for (int x = 1; x < int'(m); x++)
      if ((int'(a) * x) % int'(m) == 1) return N'(x);
    return '0;
  endfunction

  // Core stub: result_ready after `lat` cycles out of reset.
  always @(posedge clk) core_cyc <= inv_reset ? 0 : core_cyc + 1;
  assign inv_ready = force_rdy | (!inv_reset && core_cyc == lat);
  assign inv_x = force_rdy ? 8'h77 : inv_ready ? inv_mod(inv_a, p) : 8'h5a;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, ncyc, got, exp);
    end
  endtask

  // Predicts the state after the coming clock edge from the inputs now applied.
  task automatic model_step();
    if (!rst_n) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_end = 0; m_err = 0; m_res = '0; m_a = '0;
    end else if (m_end) begin
      m_ptr = (m_owner + 1) % NREQ;
      m_owner = -1;
      m_end = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++)
        if (m_owner < 0 && req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
      if (m_owner >= 0) begin
        m_a = a_in[m_owner*N +: N];
        m_age = 0;
        if (m_a == 0) begin m_end = 1; m_res = '0; m_err = 1; end
      end
    end else if (m_age >= 1 && inv_ready) begin
      m_end = 1; m_res = inv_x; m_err = 0;
    end else if (m_age == TO) begin
      m_end = 1; m_res = '0; m_err = 1;
    end else m_age++;
  endtask

  task automatic compare();
    logic [NREQ-1:0] eg;
    eg = m_owner < 0 ? '0 : NREQ'(1) << m_owner;
    chk("gnt", gnt, eg);
    chk("done", done, m_end ? eg : '0);
    chk("result", result, m_res);
    chk("err", err, m_err);
    chk("busy", busy, m_owner >= 0);
    chk("inv_reset", inv_reset, !(m_owner >= 0 && !m_end && m_age >= 1));
    chk("inv_a", inv_a, m_a);
    chk("inv_p", inv_p, p);
    chk("gnt_onehot", $onehot0(gnt), 1);
    if (prev_gnt != 0 && gnt != 0) chk("grant_gap", gnt, prev_gnt);
    prev_gnt = gnt;
  endtask

  task automatic cycle();
    #1;
    model_step();
    @(negedge clk);
    ncyc++;
    compare();
  endtask

  task automatic serve(input int w, input int bound, output int dl, output int nlow);
    int tg;
    tg = -1; dl = -1; nlow = 0;
    for (int c = 0; c < bound && dl < 0; c++) begin
      cycle();
      if (tg < 0 && gnt[w]) tg = c;
      if (!inv_reset) nlow++;
      if (done[w]) dl = c - tg;
    end
    if (dl < 0) begin
      checks++; failures++;
      $display("FAIL serve_wait req=%0d got=no_done exp=done_within_%0d", w, bound);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
  endtask

  function automatic logic [N-1:0] rand_op(input logic [N-1:0] pm);
    return $urandom_range(0, 7) == 0 ? '0 : N'($urandom_range(1, int'(pm) - 1));
  endfunction

  task automatic rand_seg(input logic [N-1:0] pm, input int ncy);
    bit quiet;
    p = pm;
    quiet = 0;
    for (int c = 0; c < ncy + 300; c++) begin
      if (c >= ncy) quiet = 1;
      if (quiet && req == 0 && m_owner < 0) break;
      cycle();
      if (done != 0 && !err) chk("inverse", (int'(result) * int'(m_a)) % int'(pm), 1);
      if (m_owner < 0) lat = $urandom_range(0, 20);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && done[i]) begin
          if (quiet || $urandom_range(0, 1) == 1) req[i] = 0;
          else a_in[i*N +: N] = rand_op(pm);
        end else if (!req[i] && !quiet && $urandom_range(0, 2) == 0) begin
          a_in[i*N +: N] = rand_op(pm);
          req[i] = 1;
        end
      end
    end
    if (req != 0 || m_owner >= 0) begin
      checks++; failures++;
      $display("FAIL drain got=busy exp=idle");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int dl, nl, nd;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inv_reset", inv_reset, 1);
    chk("rst_result", result, 0);
    chk("rst_inv_a", inv_a, 0);
    rst_n = 1;
    cycle();

    lat = 10; a_in[0 +: N] = 3; req = 3'b001;
    serve(0, 40, dl, nl);
    chk("basic_latency", dl, 12);
    chk("basic_run_cycles", nl, 11);
    chk("basic_result", result, 5);
    chk("basic_err", err, 0);
    req = 0;
    cycle();

    do_reset();
    lat = 2; a_in[0 +: N] = 3; a_in[N +: N] = 2; req = 3'b011;
    nd = 0;
    for (int c = 0; c < 200 && nd < 4; c++) begin
      cycle();
      if (done != 0) begin
        chk("rr_order", done, nd % 2 == 0 ? 1 : 2);
        chk("rr_result", result, nd % 2 == 0 ? 5 : 4);
        nd++;
      end
    end
    if (nd < 4) begin
      checks++; failures++;
      $display("FAIL rr_wait got=%0d exp=4", nd);
    end
    req = 0;
    cycle();

    a_in[N +: N] = 0; req = 3'b010;
    serve(1, 20, dl, nl);
    chk("zero_latency", dl, 0);
    chk("zero_core_held", nl, 0);
    chk("zero_err", err, 1);
    chk("zero_result", result, 0);
    req = 0;
    cycle();

    lat = 1000; a_in[0 +: N] = 3; req = 3'b001;
    serve(0, 40, dl, nl);
    chk("timeout_latency", dl, 17);
    chk("timeout_run_cycles", nl, 16);
    chk("timeout_err", err, 1);
    chk("timeout_result", result, 0);
    req = 0;
    cycle();
    lat = 3; a_in[2*N +: N] = 5; req = 3'b100;
    serve(2, 30, dl, nl);
    chk("after_to_latency", dl, 5);
    chk("after_to_result", result, 3);
    chk("after_to_err", err, 0);
    req = 0;
    cycle();

    lat = 15; a_in[0 +: N] = 2; req = 3'b001;
    serve(0, 40, dl, nl);
    chk("edge_ready_latency", dl, 17);
    chk("edge_ready_err", err, 0);
    chk("edge_ready_result", result, 4);
    req = 0;
    cycle();

    force_rdy = 1;
    cycle();
    cycle();
    chk("idle_ready_done", done, 0);
    chk("idle_ready_busy", busy, 0);
    chk("idle_ready_result", result, 4);
    force_rdy = 0;
    cycle();

    lat = 1000; a_in[0 +: N] = 3; req = 3'b001;
    repeat (6) cycle();
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_inv_reset", inv_reset, 0);
    #2 rst_n = 0;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_done", done, 0);
    chk("async_busy", busy, 0);
    chk("async_inv_reset", inv_reset, 1);
    chk("async_inv_a", inv_a, 0);
    chk("async_result", result, 0);
    chk("async_err", err, 0);
    cycle();
    cycle();
    rst_n = 1; lat = 4;
    serve(0, 30, dl, nl);
    chk("rereq_latency", dl, 6);
    chk("rereq_result", result, 5);
    req = 0;
    cycle();

    rand_seg(8'd13, 500);
    rand_seg(8'd251, 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
